jtag_dr_bank: RTL and testbench

Parametrised JTAG data-register bank: the generalised successor of the fixed-function DR block, sitting between the TAP controller and any number of user-side register consumers (AXI bridge, reset control, debug mailboxes). It implements BYPASS, IDCODE and NUM_USER_DR uniform user data registers behind one shared shift register. Every user register has capture/update handshake pulses and an optional shift-length integrity check. TDO is driven on the falling edge with a qualifying enable.

---
 rtl/jtag_dr_bank.sv | 167 ++++++++++++++++
 tb/tb_jtag_dr_bank.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/jtag_dr_bank.sv
// JTAG data-register bank: BYPASS, IDCODE and NUM_USER_DR user registers sharing one shift register.
// Optional shift-length integrity check enabled by defining JTAG_DR_LEN_CHECK_EN.

package jtag_dr_bank_pkg;
  typedef enum logic [3:0] {
    TAP_EXIT2_DR         = 4'h0,
    TAP_EXIT1_DR         = 4'h1,
    TAP_SHIFT_DR         = 4'h2,
    TAP_PAUSE_DR         = 4'h3,
    TAP_SELECT_IR        = 4'h4,
    TAP_UPDATE_DR        = 4'h5,
    TAP_CAPTURE_DR       = 4'h6,
    TAP_SELECT_DR        = 4'h7,
    TAP_EXIT2_IR         = 4'h8,
    TAP_EXIT1_IR         = 4'h9,
    TAP_SHIFT_IR         = 4'hA,
    TAP_PAUSE_IR         = 4'hB,
    TAP_RUN_TEST_IDLE    = 4'hC,
    TAP_UPDATE_IR        = 4'hD,
    TAP_CAPTURE_IR       = 4'hE,
    TAP_TEST_LOGIC_RESET = 4'hF
  } tap_ctrl_fsm_t;
endpackage

module jtag_dr_bank
  import jtag_dr_bank_pkg::*;
#(
  parameter logic [31:0]            IDCODE_VAL   = 32'hBADC0FFE,
  parameter int unsigned            NUM_USER_DR  = 4,
  parameter int unsigned            DR_WIDTH     = 32,
  parameter logic [NUM_USER_DR-1:0] USER_RO_MASK = '0,
  parameter logic [DR_WIDTH-1:0]    USER_RST_VAL = '0,
  parameter int unsigned            SEL_W        = $clog2(NUM_USER_DR + 2)
) (
  input  logic                            tck,
  input  logic                            trstn,
  input  logic                            tdi,
  output logic                            tdo,
  output logic                            tdo_en,
  input  tap_ctrl_fsm_t                   tap_state,
  input  logic [SEL_W-1:0]                dr_sel,
  input  logic [NUM_USER_DR*DR_WIDTH-1:0] user_capture_data,
  output logic [NUM_USER_DR-1:0]          user_capture_pulse,
  output logic [NUM_USER_DR*DR_WIDTH-1:0] user_update_data,
  output logic [NUM_USER_DR-1:0]          user_update_pulse,
  output logic                            len_err
);

  logic [DR_WIDTH-1:0]             r_sr;
  logic [DR_WIDTH-1:0]             w_sr_nxt;
  logic [DR_WIDTH-1:0]             w_cap_data;
  logic [NUM_USER_DR-1:0]          w_user_sel;
  logic                            w_is_idcode;
  logic                            w_is_user;
  logic                            w_len_ok;
  logic [NUM_USER_DR-1:0]          w_cap_nxt;
  logic [NUM_USER_DR-1:0]          w_commit;
  logic [NUM_USER_DR-1:0]          r_cap_pulse;
  logic [NUM_USER_DR-1:0]          r_upd_pulse;
  logic [NUM_USER_DR*DR_WIDTH-1:0] r_upd;
  logic                            r_tdo;
  logic                            r_tdo_en;

  // Out-of-range selects fall through to BYPASS because no decode bit is set.
  always_comb begin
    w_user_sel = '0;
    w_cap_data = '0;
    for (int unsigned i = 0; i < NUM_USER_DR; i++) begin
      if (dr_sel == SEL_W'(i + 2)) begin
        w_user_sel[i] = 1'b1;
        w_cap_data    = user_capture_data[i*DR_WIDTH +: DR_WIDTH];
      end
    end
    w_is_idcode = (dr_sel == SEL_W'(1));
    w_is_user   = |w_user_sel;
  end

  always_comb begin
    w_sr_nxt = r_sr;
    if (tap_state == TAP_CAPTURE_DR) begin
      if (w_is_user)        w_sr_nxt        = w_cap_data;
      else if (w_is_idcode) w_sr_nxt[31:0]  = IDCODE_VAL;
      else                  w_sr_nxt[0]     = 1'b0;
    end else if (tap_state == TAP_SHIFT_DR) begin
      if (w_is_user)        w_sr_nxt        = {tdi, r_sr[DR_WIDTH-1:1]};
      else if (w_is_idcode) w_sr_nxt[31:0]  = {tdi, r_sr[31:1]};
      else                  w_sr_nxt[0]     = tdi;
    end
  end

  always_comb begin
    w_cap_nxt = (tap_state == TAP_CAPTURE_DR) ? w_user_sel : '0;
    w_commit  = '0;
    if (tap_state == TAP_UPDATE_DR) begin
      w_commit = w_user_sel & ~USER_RO_MASK & {NUM_USER_DR{w_len_ok}};
    end
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      r_sr        <= '0;
      r_cap_pulse <= '0;
      r_upd_pulse <= '0;
      r_upd       <= {NUM_USER_DR{USER_RST_VAL}};
    end else begin
      r_sr        <= w_sr_nxt;
      r_cap_pulse <= w_cap_nxt;
      r_upd_pulse <= w_commit;
      if (tap_state == TAP_TEST_LOGIC_RESET) begin
        r_upd <= {NUM_USER_DR{USER_RST_VAL}};
      end else begin
        for (int unsigned i = 0; i < NUM_USER_DR; i++) begin
          if (w_commit[i]) r_upd[i*DR_WIDTH +: DR_WIDTH] <= r_sr;
        end
      end
    end
  end

`ifdef JTAG_DR_LEN_CHECK_EN
  localparam int unsigned CNT_W = $clog2(DR_WIDTH + 2);

  logic [CNT_W-1:0] r_shift_cnt;
  logic             r_len_err;

  assign w_len_ok = (r_shift_cnt == CNT_W'(DR_WIDTH));

  // Counter saturates one past DR_WIDTH so over-long scans stay distinguishable.
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      r_shift_cnt <= '0;
      r_len_err   <= 1'b0;
    end else if (tap_state == TAP_TEST_LOGIC_RESET || tap_state == TAP_CAPTURE_DR) begin
      r_shift_cnt <= '0;
      r_len_err   <= 1'b0;
    end else begin
      if (tap_state == TAP_SHIFT_DR && r_shift_cnt != CNT_W'(DR_WIDTH + 1)) begin
        r_shift_cnt <= r_shift_cnt + CNT_W'(1);
      end
      if (tap_state == TAP_UPDATE_DR && w_is_user && !w_len_ok) begin
        r_len_err <= 1'b1;
      end
    end
  end

  assign len_err = r_len_err;
`else
  assign w_len_ok = 1'b1;
  assign len_err  = 1'b0;
`endif

  always_ff @(negedge tck or negedge trstn) begin
    if (!trstn) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= (tap_state == TAP_SHIFT_DR) ? r_sr[0] : 1'b0;
      r_tdo_en <= (tap_state == TAP_SHIFT_DR);
    end
  end

  assign tdo                = r_tdo;
  assign tdo_en             = r_tdo_en;
  assign user_capture_pulse = r_cap_pulse;
  assign user_update_pulse  = r_upd_pulse;
  assign user_update_data   = r_upd;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Directed self-checking bench for jtag_dr_bank (4 user registers, register 1 read-only).
module tb_jtag_dr_bank;
  import jtag_dr_bank_pkg::*;

  logic          tck = 1'b0;
  logic          trstn = 1'b0;
  logic          tdi = 1'b0;
  logic          tdo, tdo_en, len_err;
  tap_ctrl_fsm_t tap_state = TAP_TEST_LOGIC_RESET;
  logic [2:0]    dr_sel = '0;
  logic [127:0]  cap_data = '0;
  logic [3:0]    cap_pulse, upd_pulse;
  logic [127:0]  upd_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] dout;
  logic [3:0]  cap_seen, cap_after, upd_seen, upd_after;
  logic        en_cap, en_shift_ok, en_after, len_after_cap;

  jtag_dr_bank #(
    .IDCODE_VAL  (32'hBADC0FFE),
    .NUM_USER_DR (4),
    .DR_WIDTH    (32),
    .USER_RO_MASK(4'b0010),
    .USER_RST_VAL(32'h0)
  ) u_dut (
    .tck               (tck),
    .trstn             (trstn),
    .tdi               (tdi),
    .tdo               (tdo),
    .tdo_en            (tdo_en),
    .tap_state         (tap_state),
    .dr_sel            (dr_sel),
    .user_capture_data (cap_data),
    .user_capture_pulse(cap_pulse),
    .user_update_data  (upd_data),
    .user_update_pulse (upd_pulse),
    .len_err           (len_err)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
  task automatic cyc(input tap_ctrl_fsm_t st, input logic b);
    tap_state = st;
    tdi       = b;
    @(posedge tck);
    #1;
  endtask

  task automatic scan(input logic [2:0] sel, input logic [31:0] din, input int n);
    dr_sel = sel;
    cyc(TAP_SELECT_DR, 1'b0);
    cyc(TAP_CAPTURE_DR, 1'b0);
    cap_seen      = cap_pulse;
    en_cap        = tdo_en;
    len_after_cap = len_err;
    dout          = '0;
    en_shift_ok   = 1'b1;
    for (int k = 0; k < n; k++) begin
      cyc(TAP_SHIFT_DR, din[k]);
      dout[k] = tdo;
      if (tdo_en !== 1'b1) en_shift_ok = 1'b0;
      if (k == 0) cap_after = cap_pulse;
    end
    cyc(TAP_EXIT1_DR, 1'b0);
    en_after = tdo_en;
    cyc(TAP_UPDATE_DR, 1'b0);
    upd_seen = upd_pulse;
    cyc(TAP_RUN_TEST_IDLE, 1'b0);
    upd_after = upd_pulse;
  endtask

  initial begin
    #3;
    check("rst_tdo", tdo, 1'b0);
    check("rst_tdo_en", tdo_en, 1'b0);
    check("rst_upd_lo", upd_data[63:0], 64'h0);
    check("rst_upd_hi", upd_data[127:64], 64'h0);
    check("rst_pulses", {cap_pulse, upd_pulse}, 8'h00);
    check("rst_len_err", len_err, 1'b0);
    @(posedge tck); #1;
    trstn = 1'b1;
    cyc(TAP_TEST_LOGIC_RESET, 1'b0);
    cyc(TAP_RUN_TEST_IDLE, 1'b0);

    // IDCODE
    scan(3'd1, 32'h0, 32);
    check("idcode_tdo", dout, 32'hBADC0FFE);
    check("idcode_en_cap", en_cap, 1'b0);
    check("idcode_en_shift", en_shift_ok, 1'b1);
    check("idcode_en_exit", en_after, 1'b0);
    check("idcode_no_pulse", {cap_seen, upd_seen}, 8'h00);

    // BYPASS: tdi 1,0,1,1 -> tdo 0,1,0,1
    scan(3'd0, 32'hD, 4);
    check("bypass_tdo", dout, 32'hA);

    // User register 0 write then read back
    cap_data[31:0] = 32'hCAFE0001;
    scan(3'd2, 32'hDEADBEEF, 32);
    check("u0_tdo", dout, 32'hCAFE0001);
    check("u0_cap_pulse", cap_seen, 4'b0001);
    check("u0_cap_1cyc", cap_after, 4'b0000);
    check("u0_upd_pulse", upd_seen, 4'b0001);
    check("u0_upd_1cyc", upd_after, 4'b0000);
    check("u0_upd_data", upd_data[31:0], 32'hDEADBEEF);
    cap_data[31:0] = 32'h12345678;
    scan(3'd2, 32'h0F0F0F0F, 32);
    check("u0_rescan_tdo", dout, 32'h12345678);
    check("u0_rescan_cap", cap_seen, 4'b0001);
    check("u0_rescan_data", upd_data[31:0], 32'h0F0F0F0F);

    // Read-only register 1
    cap_data[63:32] = 32'hA5A5A5A5;
    scan(3'd3, 32'hFFFFFFFF, 32);
    check("ro_tdo", dout, 32'hA5A5A5A5);
    check("ro_cap_pulse", cap_seen, 4'b0010);
    check("ro_upd_pulse", upd_seen, 4'b0000);
    check("ro_upd_data", upd_data[63:32], 32'h0);

    // Short scan (31 shifts) on register 2, captured value 0
    scan(3'd4, 32'h13572468, 31);
`ifdef JTAG_DR_LEN_CHECK_EN
    check("len_upd_pulse", upd_seen, 4'b0000);
    check("len_upd_data", upd_data[95:64], 32'h0);
    check("len_err_set", len_err, 1'b1);
`else
    check("len_upd_pulse", upd_seen, 4'b0100);
    check("len_upd_data", upd_data[95:64], 32'h26AE48D0);
    check("len_err_off", len_err, 1'b0);
`endif
    scan(3'd4, 32'h55AA55AA, 32);
    check("len_err_cap_clr", len_after_cap, 1'b0);
    check("len_full_data", upd_data[95:64], 32'h55AA55AA);
    check("len_full_pulse", upd_seen, 4'b0100);
    check("len_err_full", len_err, 1'b0);

    // Asynchronous reset in the middle of a scan of register 3
    dr_sel = 3'd5;
    cyc(TAP_SELECT_DR, 1'b0);
    cyc(TAP_CAPTURE_DR, 1'b0);
    for (int k = 0; k < 10; k++) cyc(TAP_SHIFT_DR, 1'b1);
    trstn = 1'b0;
    #2;
    check("mid_rst_tdo", {tdo, tdo_en}, 2'b00);
    check("mid_rst_pulses", {cap_pulse, upd_pulse}, 8'h00);
    check("mid_rst_u0", upd_data[31:0], 32'h0);
    check("mid_rst_u2", upd_data[95:64], 32'h0);
    check("mid_rst_len", len_err, 1'b0);
    trstn = 1'b1;
    cyc(TAP_RUN_TEST_IDLE, 1'b0);
    check("mid_rst_no_pulse", upd_pulse, 4'b0000);
    scan(3'd5, 32'hC001D00D, 32);
    check("post_rst_pulse", upd_seen, 4'b1000);
    check("post_rst_data", upd_data[127:96], 32'hC001D00D);

    // TEST_LOGIC_RESET clears update registers without pulses
    cyc(TAP_TEST_LOGIC_RESET, 1'b0);
    check("tlr_data", upd_data[127:96], 32'h0);
    check("tlr_pulses", {cap_pulse, upd_pulse}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
